// File: rtl/pll_pkg.sv
// rtl/pll_pkg.sv - shared types, default constants and saturation helpers for the PLL loop filter
//
// Contents:
//   state_e         : window FSM states (IDLE, MEASURE, UPDATE)
//   DEF_*           : default widths, gains and window limit
//   sat_signed      : clamp a signed value to a w-bit two's complement range
//   clamp_unsigned  : clamp a signed value to [0, 2^w-1]
package pll_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    UPDATE  = 2'd2
  } state_e;

  localparam int DEF_CTRL_WIDTH = 12;
  localparam int DEF_CTRL_INIT  = 2048;
  localparam int DEF_ERR_WIDTH  = 10;
  localparam int DEF_INT_WIDTH  = 16;
  localparam int DEF_KP_SHIFT   = 2;
  localparam int DEF_KI_SHIFT   = 0;
  localparam int DEF_MAX_WINDOW = 255;

  // Results are returned 32 bits wide; callers size-cast down to w bits,
  // which is lossless because the value already fits.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

  function automatic logic [31:0] clamp_unsigned(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    hi = (32'sd1 <<< w) - 32'sd1;
    if (v < 32'sd0) begin
      return 32'd0;
    end else if (v > hi) begin
      return hi;
    end
    return v;
  endfunction

endpackage

// File: rtl/pi_update.sv
// rtl/pi_update.sv - combinational proportional-integral step applied once per window
//
// Ports:
//   err     in  ERR_WIDTH signed   phase-error count of the finished window
//   integ   in  INT_WIDTH signed   current integrator value
//   integ_n out INT_WIDTH signed   saturated next integrator value
//   ctrl_n  out CTRL_WIDTH         clamped next control word
module pi_update
  import pll_pkg::*;
#(
  parameter int CTRL_WIDTH = DEF_CTRL_WIDTH,
  parameter int CTRL_INIT  = DEF_CTRL_INIT,
  parameter int ERR_WIDTH  = DEF_ERR_WIDTH,
  parameter int INT_WIDTH  = DEF_INT_WIDTH,
  parameter int KP_SHIFT   = DEF_KP_SHIFT,
  parameter int KI_SHIFT   = DEF_KI_SHIFT
) (
  input  logic signed [ERR_WIDTH-1:0]  err,
  input  logic signed [INT_WIDTH-1:0]  integ,
  output logic signed [INT_WIDTH-1:0]  integ_n,
  output logic        [CTRL_WIDTH-1:0] ctrl_n
);

  // Three guard bits cover the integrator plus both gain terms and the centre offset.
  localparam int SW = INT_WIDTH + 3;

  logic signed [SW-1:0] err_w;
  logic signed [SW-1:0] ki_term;
  logic signed [SW-1:0] integ_sum;
  logic signed [SW-1:0] prop;
  logic signed [SW-1:0] init_w;
  logic signed [SW-1:0] sum;

  always_comb begin
    err_w     = SW'(err);
    ki_term   = err_w <<< KI_SHIFT;
    integ_sum = SW'(integ) + ki_term;
    // Anti-windup: integrator sticks at its rails instead of wrapping.
    integ_n   = INT_WIDTH'(sat_signed(32'(integ_sum), INT_WIDTH));
    prop      = err_w <<< KP_SHIFT;
    init_w    = SW'(CTRL_INIT);
    sum       = init_w + SW'(integ_n) + prop;
    ctrl_n    = CTRL_WIDTH'(clamp_unsigned(32'(sum), CTRL_WIDTH));
  end

endmodule

// File: rtl/charge_pump_loop_filter.sv
// rtl/charge_pump_loop_filter.sv - digital charge pump with windowed PI loop filter
//
// Ports:
//   clk                    in  1           system clock, rising edge
//   reset                  in  1           synchronous active-high reset
//   input_up_digital       in  1           PFD up pulse (reference leads)
//   input_down_digital     in  1           PFD down pulse (feedback leads)
//   output_control_digital out CTRL_WIDTH  saturated unsigned control word
//   output_valid_digital   out 1           one-cycle strobe on control update
//   output_timeout_digital out 1           with valid when the window was cut at MAX_WINDOW
module charge_pump_loop_filter
  import pll_pkg::*;
#(
  parameter int CTRL_WIDTH = DEF_CTRL_WIDTH,
  parameter int CTRL_INIT  = DEF_CTRL_INIT,
  parameter int ERR_WIDTH  = DEF_ERR_WIDTH,
  parameter int INT_WIDTH  = DEF_INT_WIDTH,
  parameter int KP_SHIFT   = DEF_KP_SHIFT,
  parameter int KI_SHIFT   = DEF_KI_SHIFT,
  parameter int MAX_WINDOW = DEF_MAX_WINDOW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  input_up_digital,
  input  logic                  input_down_digital,
  output logic [CTRL_WIDTH-1:0] output_control_digital,
  output logic                  output_valid_digital,
  output logic                  output_timeout_digital
);

  localparam int WIN_W = $clog2(MAX_WINDOW + 1);

  state_e                 state_q, state_d;
  logic signed [ERR_WIDTH-1:0] err_q, err_d;
  logic [WIN_W-1:0]       win_q, win_d;
  logic signed [INT_WIDTH-1:0] integ_q, integ_d;
  logic [CTRL_WIDTH-1:0]  ctrl_q, ctrl_d;
  logic                   valid_q, valid_d;
  logic                   timeout_q, timeout_d;
  logic                   forced_q, forced_d;

  logic                   active;
  logic signed [1:0]      pump;
  logic signed [ERR_WIDTH-1:0] err_start;
  logic signed [ERR_WIDTH-1:0] err_acc;
  logic signed [INT_WIDTH-1:0] integ_n;
  logic [CTRL_WIDTH-1:0]  ctrl_n;

  pi_update #(
    .CTRL_WIDTH (CTRL_WIDTH),
    .CTRL_INIT  (CTRL_INIT),
    .ERR_WIDTH  (ERR_WIDTH),
    .INT_WIDTH  (INT_WIDTH),
    .KP_SHIFT   (KP_SHIFT),
    .KI_SHIFT   (KI_SHIFT)
  ) u_pi_update (
    .err     (err_q),
    .integ   (integ_q),
    .integ_n (integ_n),
    .ctrl_n  (ctrl_n)
  );

  always_comb begin
    active = input_up_digital | input_down_digital;
    if (input_up_digital && !input_down_digital) begin
      pump = 2'sd1;
    end else if (input_down_digital && !input_up_digital) begin
      pump = -2'sd1;
    end else begin
      pump = 2'sd0;
    end
    err_start = ERR_WIDTH'(pump);
    err_acc   = ERR_WIDTH'(sat_signed(32'(err_q) + 32'(pump), ERR_WIDTH));
  end

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    win_d     = win_q;
    integ_d   = integ_q;
    ctrl_d    = ctrl_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    forced_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (active) begin
          err_d   = err_start;
          win_d   = WIN_W'(1);
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (!active) begin
          state_d = UPDATE;
        end else begin
          err_d = err_acc;
          win_d = win_q + 1'b1;
          if (win_q == WIN_W'(MAX_WINDOW - 1)) begin
            state_d  = UPDATE;
            forced_d = 1'b1;
          end
        end
      end
      UPDATE: begin
        integ_d   = integ_n;
        ctrl_d    = ctrl_n;
        valid_d   = 1'b1;
        timeout_d = forced_q;
        // A pulse seen during UPDATE opens the next window right away.
        if (active) begin
          err_d   = err_start;
          win_d   = WIN_W'(1);
          state_d = MEASURE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      err_q     <= '0;
      win_q     <= '0;
      integ_q   <= '0;
      ctrl_q    <= CTRL_WIDTH'(CTRL_INIT);
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      forced_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      win_q     <= win_d;
      integ_q   <= integ_d;
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      forced_q  <= forced_d;
    end
  end

  assign output_control_digital = ctrl_q;
  assign output_valid_digital   = valid_q;
  assign output_timeout_digital = timeout_q;

endmodule

// File: tb/tb_charge_pump_loop_filter.sv
// tb/tb_charge_pump_loop_filter.sv - scoreboard bench for charge_pump_loop_filter
module tb_charge_pump_loop_filter;

  localparam int CW   = 12;
  localparam int INIT = 2048;
  localparam int MAXW = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          up = 1'b0;
  logic          down = 1'b0;
  logic [CW-1:0] ctrl;
  logic          valid;
  logic          timeout;

  charge_pump_loop_filter dut (
    .clk                    (clk),
    .reset                  (reset),
    .input_up_digital       (up),
    .input_down_digital     (down),
    .output_control_digital (ctrl),
    .output_valid_digital   (valid),
    .output_timeout_digital (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int ctrl;
    int to;
    int due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  // Reference state: integrator value and the open chunk of consecutive active cycles.
  int integ_m = 0;
  int run_len = 0;
  int run_sum = 0;
  int last_active = 0;

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void close_chunk(input int to, input int due);
    exp_t e;
    integ_m = clampi(integ_m + run_sum * 1, -32768, 32767);
    e.ctrl  = clampi(INIT + integ_m + run_sum * 4, 0, 4095);
    e.to    = to;
    e.due   = due;
    sb_q.push_back(e);
    run_len = 0;
    run_sum = 0;
  endfunction

  task automatic drive(input logic u, input logic d, input logic r);
    @(posedge clk);
    #1;
    up    = u;
    down  = d;
    reset = r;
  endtask

  task automatic active_cycle(input logic u, input logic d);
    int p;
    drive(u, d, 1'b0);
    p = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
    run_sum = clampi(run_sum + p, -512, 511);
    run_len++;
    last_active = cyc;
    if (run_len == MAXW) close_chunk(1, cyc + 2);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      if (i == 0 && run_len > 0) close_chunk(0, last_active + 3);
    end
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    sb_q.delete();
    run_len = 0;
    run_sum = 0;
    integ_m = 0;
    check("reset_ctrl", int'(ctrl), INIT);
    check("reset_valid", int'(valid), 0);
    check("reset_timeout", int'(timeout), 0);
  endtask

  task automatic repeat_active(input logic u, input logic d, input int n);
    for (int i = 0; i < n; i++) active_cycle(u, d);
  endtask

  always @(negedge clk) begin
    if (timeout && !valid) begin
      checks++;
      errors++;
      $display("FAIL timeout_without_valid actual=1 required=0 (cycle %0d)", cyc);
    end
    if (valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=1 required=0 ctrl=%0d (cycle %0d)", ctrl, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("ctrl", int'(ctrl), mon_e.ctrl);
        check("timeout", int'(timeout), mon_e.to);
        check("valid_cycle", cyc, mon_e.due);
      end
    end
  end

  initial begin
    int len, mode, gap, r;

    do_reset();
    idle_cycles(20);
    check("idle_ctrl", int'(ctrl), INIT);

    repeat_active(1'b1, 1'b0, 4);
    active_cycle(1'b1, 1'b1);
    idle_cycles(5);
    repeat_active(1'b1, 1'b0, 4);
    active_cycle(1'b1, 1'b1);
    idle_cycles(5);
    check("repeat_window_ctrl", int'(ctrl), 2072);

    do_reset();
    repeat_active(1'b0, 1'b1, 3);
    idle_cycles(5);
    check("down3_ctrl", int'(ctrl), 2033);

    do_reset();
    repeat_active(1'b1, 1'b0, 300);
    idle_cycles(5);

    do_reset();
    for (int w = 0; w < 6; w++) begin
      repeat_active(1'b1, 1'b0, MAXW);
      idle_cycles(3);
    end
    check("clamp_high_ctrl", int'(ctrl), 4095);
    for (int w = 0; w < 6; w++) begin
      repeat_active(1'b0, 1'b1, MAXW);
      idle_cycles(2);
    end

    do_reset();
    repeat_active(1'b1, 1'b0, 10);
    do_reset();
    idle_cycles(4);
    check("after_mid_reset_ctrl", int'(ctrl), INIT);
    repeat_active(1'b1, 1'b0, 2);
    idle_cycles(4);
    check("fresh_window_ctrl", int'(ctrl), 2058);

    for (int w = 0; w < 30; w++) begin
      len  = $urandom_range(1, 300);
      mode = $urandom_range(0, 2);
      gap  = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        if (mode == 0) begin
          active_cycle(1'b1, 1'b0);
        end else if (mode == 1) begin
          active_cycle(1'b0, 1'b1);
        end else begin
          r = $urandom_range(1, 3);
          active_cycle(r[0], r[1]);
        end
      end
      idle_cycles(gap);
    end

    idle_cycles(6);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
